// File: rtl/vga_pkg.sv
// Default 640x480 @ 60 Hz raster constants and count widths shared by the
// timing generator, its axis counters and the bus interface.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Port widths are fixed; any timing set must keep H_TOTAL <= 2048, V_TOTAL <= 1024.
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and the pixel
// generators / sync drivers (slave); en flows upstream into the generator.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       en;
  hcount_t    hcount;
  vcount_t    vcount;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, blank, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, blank, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync pulse,
// plus look-ahead "next position is visible" and "at last position" flags.
module vga_axis_counter #(
  parameter int VISIBLE  = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter int WIDTH    = 11,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             vclk,
  input  logic             rst_n,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] VIS_END    = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(VISIBLE + FP);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(VISIBLE + FP + SYNC);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = (count_q == LAST) ? '0 : count_q + ONE;
    end
  end

  // Sync and active are decoded from the next count so they land on the same edge.
  assign sync_d = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign active = (count_d < VIS_END);
  assign wrap   = (count_q == LAST);

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, syncs, blank,
// line/frame strobes and a free-running frame counter, all registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic               vclk,
  input  logic               rst_n,
  vga_timing_gen_if.master   vif
);

  logic    hWrap, vWrap, hActive, vActive, vStep;
  hcount_t hCount;
  vcount_t vCount;
  logic    hSync, vSync;

  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       blank_q, blank_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign vStep = vif.en & hWrap;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .WIDTH   (HCOUNT_W),
    .SYNC_POL(SYNC_POL)
  ) u_h (
    .vclk  (vclk),
    .rst_n (rst_n),
    .step  (vif.en),
    .count (hCount),
    .sync  (hSync),
    .active(hActive),
    .wrap  (hWrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .WIDTH   (VCOUNT_W),
    .SYNC_POL(SYNC_POL)
  ) u_v (
    .vclk  (vclk),
    .rst_n (rst_n),
    .step  (vStep),
    .count (vCount),
    .sync  (vSync),
    .active(vActive),
    .wrap  (vWrap)
  );

  // Strobes mark the edge on which the counters land on 0 through a wrap, never via reset.
  always_comb begin
    line_start_d  = vif.en & hWrap;
    frame_start_d = vif.en & hWrap & vWrap;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    blank_d       = vif.en ? ~(hActive & vActive) : blank_q;
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      blank_q       <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      blank_q       <= blank_d;
    end
  end

  assign vif.hcount      = hCount;
  assign vif.vcount      = vCount;
  assign vif.hsync       = hSync;
  assign vif.vsync       = vSync;
  assign vif.blank       = blank_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for line-level checks, plus a tiny
// 15x10 raster instance so vsync, frame wrap and 256-frame rollover stay short.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic vclk = 1'b0;
  always #5 vclk = ~vclk;

  logic rstNA, rstNB;
  int   checkCount, errorCount;

  // Reference state for the small raster (H_TOTAL 15, V_TOTAL 10).
  int   mh, mv, mfc;
  logic expLs, expFs;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();

  vga_timing_gen dutA (
    .vclk (vclk),
    .rst_n(rstNA),
    .vif  (ifa)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL (1'b0)
  ) dutB (
    .vclk (vclk),
    .rst_n(rstNB),
    .vif  (ifb)
  );

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic advanceB(input logic enVal);
    ifb.en = enVal;
    @(posedge vclk);
    expLs = 1'b0;
    expFs = 1'b0;
    if (enVal) begin
      expLs = (mh == 14);
      expFs = expLs && (mv == 9);
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 9) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (expFs) mfc = (mfc + 1) % 256;
    end
    #1;
  endtask

  task automatic test_reset();
    rstNA  = 1'b0;
    ifa.en = 1'b1;
    repeat (3) tick();
    checkCount += 8;
    if (ifa.hcount !== 11'd0) begin errorCount++; $display("[TB] FAIL reset_hcount got %0d want 0", ifa.hcount); end
    if (ifa.vcount !== 10'd0) begin errorCount++; $display("[TB] FAIL reset_vcount got %0d want 0", ifa.vcount); end
    if (ifa.hsync !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_hsync got %b want 1", ifa.hsync); end
    if (ifa.vsync !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_vsync got %b want 1", ifa.vsync); end
    if (ifa.blank !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_blank got %b want 0", ifa.blank); end
    if (ifa.line_start !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_line_start got %b want 0", ifa.line_start); end
    if (ifa.frame_start !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_frame_start got %b want 0", ifa.frame_start); end
    if (ifa.frame_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL reset_frame_cnt got %0d want 0", ifa.frame_cnt); end
    rstNA = 1'b1;
    tick();
    checkCount += 4;
    if (ifa.hcount !== 11'd1) begin errorCount++; $display("[TB] FAIL exit_hcount got %0d want 1", ifa.hcount); end
    if (ifa.vcount !== 10'd0) begin errorCount++; $display("[TB] FAIL exit_vcount got %0d want 0", ifa.vcount); end
    if (ifa.line_start !== 1'b0) begin errorCount++; $display("[TB] FAIL exit_line_start got %b want 0", ifa.line_start); end
    if (ifa.frame_start !== 1'b0) begin errorCount++; $display("[TB] FAIL exit_frame_start got %b want 0", ifa.frame_start); end
  endtask

  task automatic test_line();
    int   eh, ev;
    logic ehs, ebl, els;
    for (int h = 2; h <= 800; h++) begin
      tick();
      eh  = h % 800;
      ev  = (h == 800) ? 1 : 0;
      ehs = !((eh >= 656) && (eh < 752));
      ebl = (eh >= 640);
      els = (h == 800);
      checkCount += 6;
      if (ifa.hcount !== 11'(eh)) begin errorCount++; $display("[TB] FAIL line_hcount got %0d want %0d", ifa.hcount, eh); end
      if (ifa.vcount !== 10'(ev)) begin errorCount++; $display("[TB] FAIL line_vcount at h=%0d got %0d want %0d", eh, ifa.vcount, ev); end
      if (ifa.hsync !== ehs) begin errorCount++; $display("[TB] FAIL line_hsync at h=%0d got %b want %b", eh, ifa.hsync, ehs); end
      if (ifa.blank !== ebl) begin errorCount++; $display("[TB] FAIL line_blank at h=%0d got %b want %b", eh, ifa.blank, ebl); end
      if (ifa.line_start !== els) begin errorCount++; $display("[TB] FAIL line_start at h=%0d got %b want %b", eh, ifa.line_start, els); end
      if (ifa.frame_start !== 1'b0) begin errorCount++; $display("[TB] FAIL line_frame_start at h=%0d got %b want 0", eh, ifa.frame_start); end
    end
  endtask

  task automatic test_hold();
    ifa.en = 1'b0;
    repeat (3) tick();
    checkCount += 4;
    if (ifa.hcount !== 11'd0) begin errorCount++; $display("[TB] FAIL hold_hcount got %0d want 0", ifa.hcount); end
    if (ifa.vcount !== 10'd1) begin errorCount++; $display("[TB] FAIL hold_vcount got %0d want 1", ifa.vcount); end
    if (ifa.line_start !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_line_start got %b want 0", ifa.line_start); end
    if (ifa.hsync !== 1'b1) begin errorCount++; $display("[TB] FAIL hold_hsync got %b want 1", ifa.hsync); end
  endtask

  task automatic test_vsync_frame();
    int   cycleIdx, lastFrame, framesSeen;
    logic ehs, evs, ebl;
    mh = 0; mv = 0; mfc = 0;
    cycleIdx = 0; lastFrame = 0; framesSeen = 0;
    ifb.en = 1'b1;
    rstNB  = 1'b1;
    for (int k = 0; k < 256 * 150; k++) begin
      advanceB(1'b1);
      cycleIdx++;
      ehs = !((mh >= 10) && (mh < 13));
      evs = !((mv >= 7) && (mv < 9));
      ebl = (mh >= 8) || (mv >= 6);
      checkCount += 8;
      if (ifb.hcount !== 11'(mh)) begin errorCount++; $display("[TB] FAIL frame_hcount got %0d want %0d", ifb.hcount, mh); end
      if (ifb.vcount !== 10'(mv)) begin errorCount++; $display("[TB] FAIL frame_vcount got %0d want %0d", ifb.vcount, mv); end
      if (ifb.hsync !== ehs) begin errorCount++; $display("[TB] FAIL frame_hsync at (%0d,%0d) got %b want %b", mh, mv, ifb.hsync, ehs); end
      if (ifb.vsync !== evs) begin errorCount++; $display("[TB] FAIL frame_vsync at (%0d,%0d) got %b want %b", mh, mv, ifb.vsync, evs); end
      if (ifb.blank !== ebl) begin errorCount++; $display("[TB] FAIL frame_blank at (%0d,%0d) got %b want %b", mh, mv, ifb.blank, ebl); end
      if (ifb.line_start !== expLs) begin errorCount++; $display("[TB] FAIL frame_line_start at (%0d,%0d) got %b want %b", mh, mv, ifb.line_start, expLs); end
      if (ifb.frame_start !== expFs) begin errorCount++; $display("[TB] FAIL frame_start at (%0d,%0d) got %b want %b", mh, mv, ifb.frame_start, expFs); end
      if (ifb.frame_cnt !== 8'(mfc)) begin errorCount++; $display("[TB] FAIL frame_cnt got %0d want %0d", ifb.frame_cnt, mfc); end
      if (ifb.frame_start === 1'b1) begin
        framesSeen++;
        checkCount++;
        if (cycleIdx - lastFrame != 150) begin errorCount++; $display("[TB] FAIL frame_period got %0d want 150", cycleIdx - lastFrame); end
        lastFrame = cycleIdx;
      end
    end
    checkCount += 2;
    if (framesSeen != 256) begin errorCount++; $display("[TB] FAIL frame_count_seen got %0d want 256", framesSeen); end
    if (ifb.frame_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL frame_cnt_wrap got %0d want 0", ifb.frame_cnt); end
  endtask

  task automatic test_en_toggle();
    for (int k = 0; k < 40; k++) begin
      advanceB((k % 2) == 0);
      checkCount += 4;
      if (ifb.hcount !== 11'(mh)) begin errorCount++; $display("[TB] FAIL toggle_hcount got %0d want %0d", ifb.hcount, mh); end
      if (ifb.vcount !== 10'(mv)) begin errorCount++; $display("[TB] FAIL toggle_vcount got %0d want %0d", ifb.vcount, mv); end
      if (ifb.line_start !== expLs) begin errorCount++; $display("[TB] FAIL toggle_line_start k=%0d got %b want %b", k, ifb.line_start, expLs); end
      if (ifb.frame_start !== expFs) begin errorCount++; $display("[TB] FAIL toggle_frame_start k=%0d got %b want %b", k, ifb.frame_start, expFs); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!((mfc == 1) && (mh == 12) && (mv == 5)) && (n < 400)) begin
      advanceB(1'b1);
      n++;
    end
    checkCount += 3;
    if (n >= 400) begin errorCount++; $display("[TB] FAIL mid_position_timeout got %0d cycles want <400", n); end
    if (ifb.frame_cnt !== 8'd1) begin errorCount++; $display("[TB] FAIL mid_pre_frame_cnt got %0d want 1", ifb.frame_cnt); end
    if (ifb.blank !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_pre_blank got %b want 1", ifb.blank); end
    #3;
    rstNB = 1'b0;
    #1;
    checkCount += 8;
    if (ifb.hcount !== 11'd0) begin errorCount++; $display("[TB] FAIL mid_rst_hcount got %0d want 0", ifb.hcount); end
    if (ifb.vcount !== 10'd0) begin errorCount++; $display("[TB] FAIL mid_rst_vcount got %0d want 0", ifb.vcount); end
    if (ifb.hsync !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_rst_hsync got %b want 1", ifb.hsync); end
    if (ifb.vsync !== 1'b1) begin errorCount++; $display("[TB] FAIL mid_rst_vsync got %b want 1", ifb.vsync); end
    if (ifb.blank !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_rst_blank got %b want 0", ifb.blank); end
    if (ifb.line_start !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_rst_line_start got %b want 0", ifb.line_start); end
    if (ifb.frame_start !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_rst_frame_start got %b want 0", ifb.frame_start); end
    if (ifb.frame_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL mid_rst_frame_cnt got %0d want 0", ifb.frame_cnt); end
    tick();
    rstNB = 1'b1;
    tick();
    checkCount += 4;
    if (ifb.hcount !== 11'd1) begin errorCount++; $display("[TB] FAIL restart_hcount got %0d want 1", ifb.hcount); end
    if (ifb.vcount !== 10'd0) begin errorCount++; $display("[TB] FAIL restart_vcount got %0d want 0", ifb.vcount); end
    if (ifb.line_start !== 1'b0) begin errorCount++; $display("[TB] FAIL restart_line_start got %b want 0", ifb.line_start); end
    if (ifb.frame_cnt !== 8'd0) begin errorCount++; $display("[TB] FAIL restart_frame_cnt got %0d want 0", ifb.frame_cnt); end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstNA  = 1'b0;
    rstNB  = 1'b0;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    test_reset();
    test_line();
    test_hold();
    test_vsync_frame();
    test_en_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
